// File: rtl/game_move_engine.sv
// Sokoban move engine: resolves walk / push / block for one direction command
// against a snapshot of the game-state register and drives its d/en inputs.
// Optional feature macro: SOKO_STEP_COUNT_EN adds a saturating 16-bit step_count.
module game_move_engine #(
  parameter int unsigned COLS  = 8,
  parameter int unsigned ROWS  = 8,
  parameter int unsigned POS_W = 6,
  parameter int unsigned N     = 2*ROWS*COLS+POS_W
) (
  input  logic         clk,
  input  logic         r,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd_dir,
  output logic         cmd_ready,
  input  logic [N-1:0] cur_state,
  output logic [N-1:0] next_state,
  output logic         commit,
  output logic         move_ok,
  output logic         move_block
`ifdef SOKO_STEP_COUNT_EN
  ,
  output logic [15:0]  step_count
`endif
);

  localparam int unsigned CELLS  = ROWS*COLS;
  localparam int unsigned CELL_W = 2*CELLS;

  typedef enum logic [1:0] {IDLE, LOOK1, LOOK2, COMMIT} state_t;

  state_t            state, nxt;
  logic [N-1:0]      snap;
  logic [1:0]        dir;
  logic [POS_W-1:0]  t1;
  logic [N-1:0]      result_d;
  logic              block_d;
  logic              off1, off2;
  logic [POS_W-1:0]  t1_d, t2_d;
  logic [1:0]        c1, c2;
  logic              accept;

  // One step from p in direction d; MSB flags off-grid (including wrap attempts).
  function automatic logic [POS_W:0] step_pos(input logic [POS_W-1:0] p, input logic [1:0] d);
    int unsigned pi, row, col, t;
    logic off;
    pi  = 32'(p);
    row = pi / COLS;
    col = pi % COLS;
    off = (pi >= CELLS);
    t   = pi;
    case (d)
      2'b00: begin off = off | (row == 0);        t = pi - COLS; end
      2'b01: begin off = off | (row >= ROWS - 1); t = pi + COLS; end
      2'b10: begin off = off | (col == 0);        t = pi - 1;    end
      2'b11: begin off = off | (col >= COLS - 1); t = pi + 1;    end
    endcase
    return {off, POS_W'(t)};
  endfunction

  // Two-bit cell code at grid index idx.
  function automatic logic [1:0] cell_at(input logic [CELL_W-1:0] cells, input logic [POS_W-1:0] idx);
    int unsigned i;
    i = 32'(idx);
    if (i >= CELLS) return 2'b01;
    return cells[2*i +: 2];
  endfunction

  assign accept = cmd_valid && cmd_ready && (state == IDLE);

  // Next-state, block decision and candidate result from the snapshot.
  always_comb begin
    nxt      = state;
    block_d  = 1'b0;
    result_d = snap;
    {off1, t1_d} = step_pos(snap[N-1 -: POS_W], dir);
    {off2, t2_d} = step_pos(t1, dir);
    c1 = cell_at(snap[CELL_W-1:0], t1_d);
    c2 = cell_at(snap[CELL_W-1:0], t2_d);
    case (state)
      IDLE: begin
        if (accept) nxt = LOOK1;
      end
      LOOK1: begin
        if (off1 || c1[0]) begin
          block_d = 1'b1;
          nxt     = IDLE;
        end else if (c1 == 2'b00) begin
          result_d[N-1 -: POS_W] = t1_d;
          nxt = COMMIT;
        end else begin
          nxt = LOOK2;
        end
      end
      LOOK2: begin
        if (!off2 && (c2 == 2'b00)) begin
          result_d[N-1 -: POS_W]       = t1;
          result_d[2*32'(t1) +: 2]     = 2'b00;
          result_d[2*32'(t2_d) +: 2]   = 2'b10;
          nxt = COMMIT;
        end else begin
          block_d = 1'b1;
          nxt     = IDLE;
        end
      end
      COMMIT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register, snapshot capture and registered outputs.
  always_ff @(posedge clk) begin
    if (r) begin
      state      <= IDLE;
      snap       <= '0;
      dir        <= 2'b00;
      t1         <= '0;
      cmd_ready  <= 1'b0;
      next_state <= '0;
      commit     <= 1'b0;
      move_ok    <= 1'b0;
      move_block <= 1'b0;
    end else begin
      state      <= nxt;
      cmd_ready  <= (nxt == IDLE);
      commit     <= (nxt == COMMIT);
      move_ok    <= (nxt == COMMIT);
      move_block <= block_d;
      if (state == LOOK1) t1 <= t1_d;
      if (accept) begin
        snap       <= cur_state;
        dir        <= cmd_dir;
        next_state <= cur_state;
      end else if (nxt == COMMIT) begin
        next_state <= result_d;
      end else if (state == COMMIT) begin
        next_state <= snap;
      end
    end
  end

`ifdef SOKO_STEP_COUNT_EN
  // Saturating count of committed moves.
  always_ff @(posedge clk) begin
    if (r) begin
      step_count <= 16'h0000;
    end else if (commit && (step_count != 16'hFFFF)) begin
      step_count <= step_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_game_move_engine.sv
// Scoreboard bench for game_move_engine: directed moves with hand-computed results.
module tb_game_move_engine;

  localparam int unsigned N = 134;

  logic         clk = 1'b0;
  logic         r;
  logic         cmd_valid;
  logic [1:0]   cmd_dir;
  logic         cmd_ready;
  logic [N-1:0] cur_state;
  logic [N-1:0] next_state;
  logic         commit;
  logic         move_ok;
  logic         move_block;
`ifdef SOKO_STEP_COUNT_EN
  logic [15:0]  step_count;
`endif

  always #5 clk = ~clk;

  game_move_engine dut (
    .clk        (clk),
    .r          (r),
    .cmd_valid  (cmd_valid),
    .cmd_dir    (cmd_dir),
    .cmd_ready  (cmd_ready),
    .cur_state  (cur_state),
    .next_state (next_state),
    .commit     (commit),
    .move_ok    (move_ok),
    .move_block (move_block)
`ifdef SOKO_STEP_COUNT_EN
    ,
    .step_count (step_count)
`endif
  );

  typedef struct {
    int           id;
    bit           ok;
    logic [N-1:0] ns;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  // Cycle counter and accept-edge stamp.
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready && !r) acc_cyc <= cyc;
    cyc <= cyc + 1;
  end

  // Monitor: pop the expected response whenever the engine reports a result.
  always @(negedge clk) begin
    exp_t e;
    if (!r && (commit || move_ok || move_block)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_out commit=%0b move_ok=%0b move_block=%0b expected none", commit, move_ok, move_block);
      end else begin
        e = sb.pop_front();
        checks++;
        if (commit !== e.ok || move_ok !== e.ok || move_block !== !e.ok) begin
          errors++;
          $display("FAIL move%0d_kind commit=%0b move_ok=%0b move_block=%0b expected ok=%0b", e.id, commit, move_ok, move_block, e.ok);
        end
        checks++;
        if ((cyc - acc_cyc) != e.lat) begin
          errors++;
          $display("FAIL move%0d_latency got %0d expected %0d", e.id, cyc - acc_cyc, e.lat);
        end
        if (e.ok) begin
          checks++;
          if (next_state !== e.ns) begin
            errors++;
            $display("FAIL move%0d_next_state got %h expected %h", e.id, next_state, e.ns);
          end
        end
      end
    end
  end

  function automatic logic [N-1:0] mk(input int pos);
    logic [N-1:0] s;
    s = '0;
    s[N-1 -: 6] = 6'(pos);
    return s;
  endfunction

  function automatic logic [N-1:0] setc(input logic [N-1:0] s, input int i, input logic [1:0] c);
    logic [N-1:0] o;
    o = s;
    o[2*i +: 2] = c;
    return o;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one command, then wait (bounded) for the monitor to consume its result.
  task automatic do_move(input int id, input logic [N-1:0] st, input logic [1:0] d,
                         input bit ok, input logic [N-1:0] ns, input int lat);
    exp_t e;
    int n;
    e.id = id; e.ok = ok; e.ns = ns; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = d; cur_state = st;
    n = 0;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    cur_state = '1;
    n = 0;
    while (sb.size() != 0 && n < 10) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL move%0d_timeout got no response expected ok=%0b", id, ok);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    r = 1'b1; cmd_valid = 1'b0; cmd_dir = 2'b00; cur_state = '0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", N'(cmd_ready), N'(0));
    chk("reset_commit", N'({commit, move_ok, move_block}), N'(0));
    chk("reset_next_state", next_state, '0);
    r = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", N'(cmd_ready), N'(1));

    do_move(1,  mk(9), 2'b11, 1'b1, mk(10), 2);
    do_move(2,  setc(mk(9), 10, 2'b10), 2'b11, 1'b1, setc(mk(10), 11, 2'b10), 3);
    do_move(3,  setc(setc(mk(9), 10, 2'b10), 11, 2'b10), 2'b11, 1'b0, '0, 3);
    do_move(4,  mk(7),  2'b11, 1'b0, '0, 2);
    do_move(5,  mk(3),  2'b00, 1'b0, '0, 2);
    do_move(6,  mk(56), 2'b01, 1'b0, '0, 2);
    do_move(7,  setc(mk(9), 8, 2'b01), 2'b10, 1'b0, '0, 2);
    do_move(8,  setc(mk(9), 10, 2'b11), 2'b11, 1'b0, '0, 2);
    do_move(9,  setc(setc(mk(9), 17, 2'b10), 25, 2'b01), 2'b01, 1'b0, '0, 3);
    do_move(10, setc(mk(6), 7, 2'b10), 2'b11, 1'b0, '0, 3);
    do_move(11, mk(9), 2'b00, 1'b1, mk(1), 2);
    do_move(12, mk(9), 2'b10, 1'b1, mk(8), 2);
    do_move(13, mk(8), 2'b10, 1'b0, '0, 2);
    do_move(14, setc(mk(1), 9, 2'b10), 2'b01, 1'b1, setc(mk(9), 17, 2'b10), 3);
    do_move(15, setc(setc(mk(17), 9, 2'b10), 0, 2'b01), 2'b00, 1'b1,
                setc(setc(mk(9), 1, 2'b10), 0, 2'b01), 3);
    do_move(16, setc(setc(mk(9), 10, 2'b10), 11, 2'b11), 2'b11, 1'b0, '0, 3);

    // Reset during LOOK2 of a push: the command is dropped.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 2'b11; cur_state = setc(mk(9), 10, 2'b10);
    n = 0;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    r = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", N'({commit, move_ok, move_block}), N'(0));
    chk("midreset_next_state", next_state, '0);
    chk("midreset_cmd_ready", N'(cmd_ready), N'(0));
    r = 1'b0;
    @(negedge clk);
    chk("midreset_ready_after", N'(cmd_ready), N'(1));
    repeat (4) @(negedge clk);

    // Three legal moves and one blocked move after reset.
    do_move(20, mk(9),  2'b11, 1'b1, mk(10), 2);
    do_move(21, mk(10), 2'b01, 1'b1, mk(18), 2);
    do_move(22, mk(7),  2'b11, 1'b0, '0, 2);
    do_move(23, setc(mk(18), 19, 2'b10), 2'b11, 1'b1, setc(mk(19), 20, 2'b10), 3);
    repeat (2) @(negedge clk);
`ifdef SOKO_STEP_COUNT_EN
    chk("step_count", N'(step_count), N'(3));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
